// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash command engine.
// Holds flash opcode constants, the sequencer state encoding and address sizing.
package spi_flash_pkg;

   // Flash opcodes
   localparam logic [7:0] OP_RDID      = 8'h9F;
   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_RDSR      = 8'h05;
   localparam logic [7:0] OP_WREN      = 8'h06;

   localparam int unsigned MAX_ADDR_BYTES = 3;
   localparam int unsigned ADDR_W         = 8 * MAX_ADDR_BYTES;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SEND_OP,
      ST_SEND_ADDR,
      ST_DUMMY,
      ST_READ,
      ST_CS_HOLD,
      ST_CS_GAP
   } state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// Bit-level SPI mode-0 engine: transfers one byte per load, MSB-first.
// Each bit is CLK_DIV clk cycles with sclk low, then CLK_DIV cycles high.
// Ports: clk, reset (sync, active-high), load/tx_byte (start a byte),
//        miso in; sclk/mosi (registered), byte_done_c (last cycle of byte),
//        rx_valid_c/rx_byte_c (8th sample edge and assembled byte).
module spi_byte_shifter #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       byte_done_c,
   output logic       rx_valid_c,
   output logic [7:0] rx_byte_c
);

   localparam int unsigned DIV_W = 8;

   logic             active;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       bit_cnt;
   logic [6:0]       tx_sr;
   logic [6:0]       rx_sr;
   logic             half_end_c;

   assign half_end_c  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign byte_done_c = half_end_c && sclk && (bit_cnt == 3'd7);
   // The 8th sample edge: the byte is complete including the current miso bit.
   assign rx_valid_c  = half_end_c && !sclk && (bit_cnt == 3'd7);
   assign rx_byte_c   = {rx_sr, miso};

   // Half-period counter, clock generation and shift registers
   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else if (load) begin
         // Load wins over the final half-period so bytes run back to back.
         active  <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         mosi    <= tx_byte[7];
         tx_sr   <= tx_byte[6:0];
      end else if (half_end_c) begin
         div_cnt <= '0;
         if (!sclk) begin
            sclk  <= 1'b1;
            rx_sr <= rx_byte_c[6:0];
         end else begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
               active <= 1'b0;
               mosi   <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
               mosi    <= tx_sr[6];
               tx_sr   <= {tx_sr[5:0], 1'b0};
            end
         end
      end else if (active) begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_flash_cmd.sv
// SPI mode-0 command engine for serial flash: opcode, 0-3 address bytes,
// optional dummy byte, then 0..MAX_RD_BYTES read bytes streamed out.
// Optional feature macro: SPI_FAST_READ_EN adds the dummy_en input and DUMMY state.
// Ports: clk, reset (sync, active-high), start/opcode/addr/addr_bytes/rd_len
//        (request, latched on accept), busy, done, rd_data, rd_valid,
//        SPICLK, SPIMOSI, SPIMISO, chip_select (active low).
module spi_flash_cmd
   import spi_flash_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned MAX_RD_BYTES = 16,
   parameter int unsigned LEN_W        = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        opcode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        addr_bytes,
   input  logic [LEN_W-1:0]  rd_len,
`ifdef SPI_FAST_READ_EN
   input  logic              dummy_en,
`endif
   output logic              busy,
   output logic              done,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              SPICLK,
   output logic              SPIMOSI,
   input  logic              SPIMISO,
   output logic              chip_select
);

   localparam int unsigned CNT_W = 8;

   state_e             state, next_state;
   logic [7:0]         op_q;
   logic [ADDR_W-1:0]  addr_sr;
   logic [1:0]         addr_left;
   logic [LEN_W-1:0]   len_left;
   logic               dummy_q;
   logic [CNT_W-1:0]   cnt;

   logic               accept_c, cnt_end_c;
   logic               load_c, addr_load_c, read_load_c;
   logic [7:0]         tx_byte_c;
   logic               byte_done_c, rx_valid_c;
   logic [7:0]         rx_byte_c;

   // A start coinciding with the done pulse is ignored.
   assign accept_c  = (state == ST_IDLE) && start && !done;
   assign cnt_end_c = (cnt == CNT_W'(CLK_DIV - 1));

`ifdef SPI_FAST_READ_EN
   // Dummy-byte request latched with the transaction
   always_ff @(posedge clk) begin
      if (reset)         dummy_q <= 1'b0;
      else if (accept_c) dummy_q <= dummy_en;
   end
`else
   assign dummy_q = 1'b0;
`endif

   spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .load        (load_c),
      .tx_byte     (tx_byte_c),
      .miso        (SPIMISO),
      .sclk        (SPICLK),
      .mosi        (SPIMOSI),
      .byte_done_c (byte_done_c),
      .rx_valid_c  (rx_valid_c),
      .rx_byte_c   (rx_byte_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Byte sequencing: decides the next byte to load at each byte boundary
   always_comb begin
      next_state  = state;
      load_c      = 1'b0;
      tx_byte_c   = 8'h00;
      addr_load_c = 1'b0;
      read_load_c = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept_c) next_state = ST_CS_SETUP;
         end
         ST_CS_SETUP: begin
            if (cnt_end_c) begin
               next_state = ST_SEND_OP;
               load_c     = 1'b1;
               tx_byte_c  = op_q;
            end
         end
         ST_SEND_OP, ST_SEND_ADDR: begin
            if (byte_done_c) begin
               if (addr_left != 2'd0) begin
                  next_state  = ST_SEND_ADDR;
                  load_c      = 1'b1;
                  tx_byte_c   = addr_sr[ADDR_W-1 -: 8];
                  addr_load_c = 1'b1;
               end else if (dummy_q) begin
                  next_state = ST_DUMMY;
                  load_c     = 1'b1;
               end else if (len_left != '0) begin
                  next_state  = ST_READ;
                  load_c      = 1'b1;
                  read_load_c = 1'b1;
               end else begin
                  next_state = ST_CS_HOLD;
               end
            end
         end
         ST_DUMMY, ST_READ: begin
            if (byte_done_c) begin
               if (len_left != '0) begin
                  next_state  = ST_READ;
                  load_c      = 1'b1;
                  read_load_c = 1'b1;
               end else begin
                  next_state = ST_CS_HOLD;
               end
            end
         end
         ST_CS_HOLD: begin
            if (cnt_end_c) next_state = ST_CS_GAP;
         end
         ST_CS_GAP: begin
            if (cnt_end_c) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Request latching, phase counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q        <= '0;
         addr_sr     <= '0;
         addr_left   <= '0;
         len_left    <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         chip_select <= 1'b1;
      end else begin
         cnt         <= (next_state != state) ? '0 : cnt + CNT_W'(1);
         busy        <= (next_state != ST_IDLE);
         done        <= (state == ST_CS_GAP) && cnt_end_c;
         chip_select <= (next_state == ST_IDLE) || (next_state == ST_CS_GAP);
         rd_valid    <= rx_valid_c && (state == ST_READ);
         if (rx_valid_c && (state == ST_READ)) rd_data <= rx_byte_c;

         if (accept_c) begin
            op_q      <= opcode;
            addr_left <= addr_bytes;
            len_left  <= (rd_len > LEN_W'(MAX_RD_BYTES)) ? LEN_W'(MAX_RD_BYTES) : rd_len;
            // Left-align the bytes to send so they leave from the top.
            unique case (addr_bytes)
               2'd1:    addr_sr <= {addr[7:0], 16'h0000};
               2'd2:    addr_sr <= {addr[15:0], 8'h00};
               default: addr_sr <= addr;
            endcase
         end
         if (addr_load_c) begin
            addr_sr   <= {addr_sr[ADDR_W-9:0], 8'h00};
            addr_left <= addr_left - 2'd1;
         end
         if (read_load_c) len_left <= len_left - LEN_W'(1);
      end
   end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Self-checking bench for spi_flash_cmd: behavioural flash model, randomized
// and directed transactions, checked against frame-level expectations.
module tb_spi_flash_cmd;
   import spi_flash_pkg::*;

   localparam int unsigned D    = 2;
   localparam int unsigned MAXB = 16;
   localparam int unsigned LW   = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    opcode = '0;
   logic [23:0]   addr = '0;
   logic [1:0]    addr_bytes = '0;
   logic [LW-1:0] rd_len = '0;
   logic          dummy_en = 1'b0;
   logic          busy, done, rd_valid, SPICLK, SPIMOSI, chip_select;
   logic [7:0]    rd_data;
   logic          miso_r = 1'b0;

   int vectors = 0;
   int errors  = 0;

   // Flash model and monitor state
   logic [7:0] resp [MAXB];
   int         cmd_bits = 8;
   int         rise = 0;
   bit         mosi_q[$];
   bit         exp_mosi[$];
   logic [7:0] rd_q[$];
   int         cs_low = 0;
   int         done_cnt = 0;
   int         exp_len, exp_cs;

   always #5 clk = ~clk;

   spi_flash_cmd #(.CLK_DIV(D), .MAX_RD_BYTES(MAXB), .LEN_W(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .opcode      (opcode),
      .addr        (addr),
      .addr_bytes  (addr_bytes),
      .rd_len      (rd_len),
`ifdef SPI_FAST_READ_EN
      .dummy_en    (dummy_en),
`endif
      .busy        (busy),
      .done        (done),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .SPICLK      (SPICLK),
      .SPIMOSI     (SPIMOSI),
      .SPIMISO     (miso_r),
      .chip_select (chip_select)
   );

   // Response bit k of the frame: zero during command bits, then resp bytes MSB-first
   function automatic logic resp_bit(input int k);
      int j;
      if (k < cmd_bits) return 1'b0;
      j = k - cmd_bits;
      if (j / 8 >= int'(MAXB)) return 1'b0;
      return resp[j / 8][7 - (j % 8)];
   endfunction

   // Flash: capture MOSI on SPICLK rise, present the next MISO bit after it
   always @(posedge SPICLK or negedge chip_select) begin
      if (SPICLK && !chip_select) begin
         mosi_q.push_back(SPIMOSI);
         rise++;
      end else if (!chip_select) begin
         rise = 0;
      end
      miso_r = resp_bit(rise);
   end

   always @(negedge clk) begin
      if (chip_select === 1'b0) cs_low++;
      if (rd_valid === 1'b1) rd_q.push_back(rd_data);
      if (done === 1'b1) done_cnt++;
   end

   task automatic fill_resp();
      for (int i = 0; i < int'(MAXB); i++) resp[i] = 8'($urandom);
   endtask

   task automatic clear_mon();
      mosi_q.delete();
      rd_q.delete();
      cs_low   = 0;
      done_cnt = 0;
   endtask

   // Frame-level expectations from the request alone
   task automatic set_expect(input logic [7:0] op, input logic [23:0] a, input int ab,
                             input int len, input int dm);
      int le;
      le       = (len > int'(MAXB)) ? int'(MAXB) : len;
      cmd_bits = (1 + ab + dm) * 8;
      exp_len  = le;
      exp_cs   = 2 * D + (1 + ab + dm + le) * 16 * D;
      exp_mosi.delete();
      for (int i = 7; i >= 0; i--) exp_mosi.push_back(op[i]);
      for (int b = ab - 1; b >= 0; b--)
         for (int i = 7; i >= 0; i--) exp_mosi.push_back(a[8 * b + i]);
      for (int i = 0; i < (dm + le) * 8; i++) exp_mosi.push_back(1'b0);
   endtask

   task automatic drive_req(input logic [7:0] op, input logic [23:0] a, input int ab,
                            input int len, input int dm);
      opcode     = op;
      addr       = a;
      addr_bytes = 2'(ab);
      rd_len     = LW'(len);
      dummy_en   = 1'(dm);
   endtask

   task automatic launch(input logic [7:0] op, input logic [23:0] a, input int ab,
                         input int len, input int dm);
      set_expect(op, a, ab, len, dm);
      @(negedge clk);
      clear_mon();
      drive_req(op, a, ab, len, dm);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || chip_select !== 1'b0)
         $display("FAIL accept: busy=%b cs=%b, required busy=1 cs=0", busy, chip_select);
      if (busy !== 1'b1 || chip_select !== 1'b0) errors++;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         errors++;
         $display("FAIL %s timeout: no done within 3000 cycles", name);
      end
   endtask

   task automatic check_txn(input string name);
      int bad = -1;
      vectors++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
      end
      vectors++;
      if (rd_q.size() != exp_len) begin
         errors++;
         $display("FAIL %s rd_count: got %0d required %0d", name, rd_q.size(), exp_len);
      end
      for (int i = 0; i < rd_q.size() && i < exp_len; i++) begin
         vectors++;
         if (rd_q[i] !== resp[i]) begin
            errors++;
            $display("FAIL %s rd_data[%0d]: got %h required %h", name, i, rd_q[i], resp[i]);
         end
      end
      vectors++;
      if (cs_low != exp_cs) begin
         errors++;
         $display("FAIL %s cs_low: got %0d required %0d", name, cs_low, exp_cs);
      end
      for (int i = 0; i < exp_mosi.size() && bad < 0; i++)
         if (i >= mosi_q.size() || mosi_q[i] != exp_mosi[i]) bad = i;
      vectors++;
      if (bad >= 0 || mosi_q.size() != exp_mosi.size()) begin
         errors++;
         $display("FAIL %s mosi: %0d bits, first bad bit %0d, required %0d bits",
                  name, mosi_q.size(), bad, exp_mosi.size());
      end
   endtask

   task automatic run_txn(input string name, input logic [7:0] op, input logic [23:0] a,
                          input int ab, input int len, input int dm);
      launch(op, a, ab, len, dm);
      wait_done(name);
      repeat (4) @(negedge clk);
      check_txn(name);
   endtask

   task automatic test_reset();
      logic [7:0] got [7];
      logic [7:0] want [7];
      reset = 1'b1;
      drive_req(OP_RDID, 24'h0, 0, 3, 0);
      start = 1'b1;
      clear_mon();
      repeat (6) @(negedge clk);
      got  = '{8'(busy), 8'(done), 8'(rd_valid), rd_data, 8'(SPICLK), 8'(SPIMOSI), 8'(chip_select)};
      want = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1};
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL reset_out%0d: got %h required %h", i, got[i], want[i]);
         end
      end
      vectors++;
      if (cs_low != 0) begin
         errors++;
         $display("FAIL reset_activity: cs low %0d cycles, required 0", cs_low);
      end
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_rdid();
      resp[0] = 8'h20; resp[1] = 8'h20; resp[2] = 8'h16;
      run_txn("rdid", OP_RDID, 24'h0, 0, 3, 0);
   endtask

   task automatic test_read();
      fill_resp();
      run_txn("read", OP_READ, 24'h012345, 3, 4, 0);
   endtask

   task automatic test_wren();
      run_txn("wren", OP_WREN, 24'h0, 0, 0, 0);
   endtask

   task automatic test_clamp();
      fill_resp();
      run_txn("clamp", OP_READ, 24'($urandom), 3, 31, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         fill_resp();
         run_txn($sformatf("rand%0d", n), 8'($urandom), 24'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 0);
      end
   endtask

   task automatic test_overlap();
      fill_resp();
      launch(OP_RDID, 24'h0, 0, 3, 0);
      repeat (20) @(negedge clk);
      drive_req(OP_WREN, 24'hABCDEF, 3, 7, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("overlap");
      repeat (60) @(negedge clk);
      check_txn("overlap");
   endtask

   task automatic test_back_to_back();
      // start only in the done cycle: must be ignored
      launch(OP_WREN, 24'h0, 0, 0, 0);
      wait_done("b2b_ign");
      drive_req(OP_RDID, 24'h0, 0, 3, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ignore busy: got %b required 0", busy);
      end
      check_txn("b2b_ign");
      // start held from the done cycle into the next: accepted one cycle later
      launch(OP_WREN, 24'h0, 0, 0, 0);
      wait_done("b2b_first");
      fill_resp();
      drive_req(OP_RDID, 24'h0, 0, 3, 0);
      start = 1'b1;
      @(negedge clk);
      check_txn("b2b_first");
      set_expect(OP_RDID, 24'h0, 0, 3, 0);
      clear_mon();
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept busy: got %b required 1", busy);
      end
      wait_done("b2b_second");
      repeat (4) @(negedge clk);
      check_txn("b2b_second");
   endtask

   task automatic test_reset_mid();
      bit reached = 1'b0;
      fill_resp();
      launch(OP_READ, 24'h00FF00, 3, 4, 0);
      for (int i = 0; i < 3000 && !reached; i++) begin
         @(negedge clk);
         if (rd_q.size() >= 2) reached = 1'b1;
      end
      vectors++;
      if (!reached) begin
         errors++;
         $display("FAIL reset_mid timeout: got %0d bytes required 2", rd_q.size());
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (chip_select !== 1'b1 || SPICLK !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid outputs: cs=%b sclk=%b busy=%b required 1 0 0",
                  chip_select, SPICLK, busy);
      end
      reset = 1'b0;
      repeat (300) @(negedge clk);
      vectors++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL reset_mid done: got %0d pulses required 0", done_cnt);
      end
      resp[0] = 8'h20; resp[1] = 8'h20; resp[2] = 8'h16;
      run_txn("rdid_after_reset", OP_RDID, 24'h0, 0, 3, 0);
   endtask

`ifdef SPI_FAST_READ_EN
   task automatic test_fast_read();
      fill_resp();
      run_txn("fast_read", OP_FAST_READ, 24'h102030, 3, 2, 1);
      fill_resp();
      run_txn("fast_read_a2", OP_FAST_READ, 24'($urandom), 2, 5, 1);
   endtask
`endif

   initial begin
      test_reset();
      test_rdid();
      test_read();
      test_wren();
      test_clamp();
      test_random();
      test_overlap();
      test_back_to_back();
      test_reset_mid();
`ifdef SPI_FAST_READ_EN
      test_fast_read();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
